// File: rtl/riscv_imm_pkg.sv
// rtl/riscv_imm_pkg.sv - immediate formats, opcodes and buffer types for imm_gen_pipe
package riscv_imm_pkg;

    // Encoding matches the extend_unit control select so downstream muxes keep working.
    typedef enum logic [2:0] {
        FMT_I    = 3'b000,
        FMT_S    = 3'b001,
        FMT_B    = 3'b010,
        FMT_J    = 3'b011,
        FMT_U    = 3'b100,
        FMT_NONE = 3'b111
    } imm_fmt_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Canonical RV64-sized entry shared with the later decode stage.
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm;
        imm_fmt_t    fmt;
        logic        illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_skid_buf.sv
// rtl/imm_skid_buf.sv - 2-entry valid/ready skid buffer, generic payload width
module imm_skid_buf
    import riscv_imm_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q, state_d;
    logic         in_ready_q, out_valid_q;
    logic [W-1:0] out_q, skid_q;
    logic         load_out, load_skid, pop_skid;

    // in_ready is accepted as 1 in EMPTY/ONE, so in_valid alone means a transfer there.
    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (in_valid) begin
                    state_d  = SKID_ONE;
                    load_out = 1'b1;
                end
            end
            SKID_ONE: begin
                if (in_valid && out_ready) begin
                    load_out = 1'b1;
                end else if (in_valid) begin
                    state_d   = SKID_FULL;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_ready) begin
                    state_d  = SKID_ONE;
                    pop_skid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= RST_VAL;
            skid_q      <= RST_VAL;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != SKID_FULL);
            out_valid_q <= (state_d != SKID_EMPTY);
            if (load_out) begin
                out_q <= in_data;
            end else if (pop_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined opcode-driven immediate generator; optional IMM_SHAMT_EN
module imm_gen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EXT64_OPS = (XLEN == 64)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_t        out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam int PW = 32 + XLEN + 3 + 1;
    localparam logic [PW-1:0] RST_ENTRY = {32'd0, {XLEN{1'b0}}, FMT_NONE, 1'b0};

    logic [6:0]      opc;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic            dec_illegal;
    logic [PW-1:0]   in_entry, out_entry;

    assign opc   = in_instr[6:0];
    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
            end
            OPC_OP_IMM_32: begin
                if (EXT64_OPS) begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_STORE:  begin dec_fmt = FMT_S; dec_imm = imm_s; end
            OPC_BRANCH: begin dec_fmt = FMT_B; dec_imm = imm_b; end
            OPC_JAL:    begin dec_fmt = FMT_J; dec_imm = imm_j; end
            OPC_LUI, OPC_AUIPC: begin dec_fmt = FMT_U; dec_imm = imm_u; end
            OPC_OP:     ;
            OPC_OP_32:  dec_illegal = !EXT64_OPS;
            default:    dec_illegal = 1'b1;
        endcase
`ifdef IMM_SHAMT_EN
        // Shifts carry funct7 in the upper immediate bits; expose only the shift amount.
        if (dec_fmt == FMT_I && (opc == OPC_OP_IMM || opc == OPC_OP_IMM_32)
            && in_instr[13:12] == 2'b01) begin
            if (XLEN == 32 || opc == OPC_OP_IMM_32) begin
                dec_imm = XLEN'(in_instr[24:20]);
            end else begin
                dec_imm = XLEN'(in_instr[25:20]);
            end
        end
`else
`endif
    end

    assign in_entry = {in_instr, dec_imm, dec_fmt, dec_illegal};

    imm_skid_buf #(
        .W       (PW),
        .RST_VAL (RST_ENTRY)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_instr   = out_entry[PW-1 -: 32];
    assign out_imm     = out_entry[XLEN+3:4];
    assign out_fmt     = imm_fmt_t'(out_entry[3:1]);
    assign out_illegal = out_entry[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (XLEN=32)
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_instr;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [31:0] SRAI_IMM =
`ifdef IMM_SHAMT_EN
        32'h0000_0003;
`else
        32'h0000_0403;
`endif

    imm_gen_pipe #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                              input logic ill, input logic [31:0] instr);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".imm"}, 64'(out_imm), 64'(imm));
        check({tag, ".fmt"}, 64'(out_fmt), 64'(fmt));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
        check({tag, ".instr"}, 64'(out_instr), 64'(instr));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_imm", 64'(out_imm), 64'd0);
        check("rst.out_fmt", 64'(out_fmt), 64'd7);
        check("rst.out_illegal", 64'(out_illegal), 64'd0);
        check("rst.out_instr", 64'(out_instr), 64'd0);
        rst_n = 1'b1;

        // single addi, 1-cycle latency
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'hFFA0_0093;
        @(negedge clk);
        expect_out("addi", 32'hFFFF_FFFA, 3'd0, 1'b0, 32'hFFA0_0093);
        in_valid = 1'b0;

        // back-to-back S/B/J/U
        @(negedge clk);
        check("b2b.idle", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_instr = 32'hFE20_AD23;
        @(negedge clk);
        expect_out("sw", 32'hFFFF_FFFA, 3'd1, 1'b0, 32'hFE20_AD23);
        in_instr = 32'hFE20_8EE3;
        @(negedge clk);
        expect_out("beq", 32'hFFFF_FFFC, 3'd2, 1'b0, 32'hFE20_8EE3);
        in_instr = 32'hFF9F_F4EF;
        @(negedge clk);
        expect_out("jal", 32'hFFFF_FFF8, 3'd3, 1'b0, 32'hFF9F_F4EF);
        in_instr = 32'h0001_A0B7;
        @(negedge clk);
        expect_out("lui", 32'h0001_A000, 3'd4, 1'b0, 32'h0001_A0B7);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b.drain", 64'(out_valid), 64'd0);

        // backpressure with illegal / add / srai
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000_007F;
        @(negedge clk);
        check("bp.in_ready1", 64'(in_ready), 64'd1);
        expect_out("illegal", 32'h0, 3'd7, 1'b1, 32'h0000_007F);
        in_instr = 32'h0020_81B3;
        @(negedge clk);
        check("bp.in_ready2", 64'(in_ready), 64'd0);
        expect_out("bp.hold1", 32'h0, 3'd7, 1'b1, 32'h0000_007F);
        in_instr = 32'h4030_D093;
        @(negedge clk);
        check("bp.in_ready3", 64'(in_ready), 64'd0);
        expect_out("bp.hold2", 32'h0, 3'd7, 1'b1, 32'h0000_007F);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.in_ready4", 64'(in_ready), 64'd1);
        expect_out("add", 32'h0, 3'd7, 1'b0, 32'h0020_81B3);
        @(negedge clk);
        expect_out("srai", SRAI_IMM, 3'd0, 1'b0, 32'h4030_D093);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp.drain", 64'(out_valid), 64'd0);

        // async reset while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFA0_0093;
        @(negedge clk);
        in_instr = 32'h0001_A0B7;
        @(negedge clk);
        check("full.in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", 64'(out_valid), 64'd0);
        check("arst.in_ready", 64'(in_ready), 64'd1);
        check("arst.out_imm", 64'(out_imm), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst.idle", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_instr = 32'hFE20_8EE3;
        @(negedge clk);
        expect_out("post_rst.first", 32'hFFFF_FFFC, 3'd2, 1'b0, 32'hFE20_8EE3);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst.drain", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
